// File: rtl/game_pkg.sv
// game_pkg: types and constants shared by the game FSM, the stage timer and the
// display path.
//   timer_state_t   stage timer FSM states
//   bcd_digit_t     one BCD digit (4 bits)
//   game_stage_t    game stage codes used by the top FSM to generate start/clear
//   preset_ok()     validity check of a {m10,m1,s10,s1} BCD preset
package game_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } timer_state_t;

  typedef enum logic [3:0] {
    STAGE_TITLE  = 4'd0,
    STAGE_READY  = 4'd1,
    STAGE_LEVEL1 = 4'd2,
    STAGE_LEVEL2 = 4'd3,
    STAGE_LEVEL3 = 4'd4,
    STAGE_BOSS   = 4'd5,
    STAGE_CLEAR  = 4'd6,
    STAGE_WIN    = 4'd7,
    STAGE_FAIL   = 4'd8
  } game_stage_t;

  localparam logic [15:0] BLANK_CODE_DEFAULT = 16'hAAAA;

  // Digits must be decimal, tens-of-seconds at most 5, and minutes within max_min.
  // Minutes are only meaningful when both minute digits are decimal, which the
  // same expression also requires, so the narrow sum cannot mislead.
  function automatic logic preset_ok(input logic [15:0] p, input logic [6:0] max_min);
    logic [6:0] mins;
    mins = 7'(p[15:12]) * 7'd10 + 7'(p[11:8]);
    return (p[15:12] <= 4'd9) && (p[11:8] <= 4'd9) && (p[7:4] <= 4'd5) &&
           (p[3:0] <= 4'd9) && (mins <= max_min);
  endfunction

endpackage

// File: rtl/stage_timer_if.sv
// stage_timer_if: control and display bundle between the game FSM (master) and
// the stage timer (slave).
//   start/pause/clear/load/capture  one-cycle control pulses from the game FSM
//   preset_bcd, mode_down, blank    levels from the game FSM
//   nums, best_nums, best_valid     time displays towards the 7-segment driver
//   running, expired, saturated, load_err, dbg_state  status back to the game FSM
// Handshake: there is no valid/ready; every control input is a single-cycle
// request that the timer acts on at the next clock edge, and every status pulse
// (expired, load_err) is high for exactly one cycle.
interface stage_timer_if;
  import game_pkg::*;

  logic         start;
  logic         pause;
  logic         clear;
  logic         load;
  logic [15:0]  preset_bcd;
  logic         mode_down;
  logic         capture;
  logic         blank;
  logic [15:0]  nums;
  logic [15:0]  best_nums;
  logic         best_valid;
  logic         running;
  logic         expired;
  logic         saturated;
  logic         load_err;
  timer_state_t dbg_state;

  modport master (
    output start, pause, clear, load, preset_bcd, mode_down, capture, blank,
    input  nums, best_nums, best_valid, running, expired, saturated, load_err,
           dbg_state
  );

  modport slave (
    input  start, pause, clear, load, preset_bcd, mode_down, capture, blank,
    output nums, best_nums, best_valid, running, expired, saturated, load_err,
           dbg_state
  );
endinterface

// File: rtl/stage_timer_counter.sv
// bcd_mmss_counter: four-digit BCD mm:ss register with increment/decrement.
//   clk, rst      clock, asynchronous active-high reset
//   i_clr         time := 00:00 (highest priority)
//   i_ld/i_ld_val time := i_ld_val
//   i_inc/i_dec   one second up (carry chain) / down (borrow chain)
//   o_time        {m10,m1,s10,s1}
//   o_is_zero/o_is_max      current time is 00:00 / MAX_MIN:59
//   o_next_zero/o_next_max  one more dec/inc reaches the terminal value
module bcd_mmss_counter
  import game_pkg::*;
#(
  parameter int MAX_MIN = 99
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_ld,
  input  logic [15:0] i_ld_val,
  input  logic        i_inc,
  input  logic        i_dec,
  output logic [15:0] o_time,
  output logic        o_is_zero,
  output logic        o_is_max,
  output logic        o_next_zero,
  output logic        o_next_max
);
  localparam bcd_digit_t MAX_M10 = bcd_digit_t'(MAX_MIN / 10);
  localparam bcd_digit_t MAX_M1  = bcd_digit_t'(MAX_MIN % 10);

  bcd_digit_t r_m10, r_m1, r_s10, r_s1;
  bcd_digit_t w_m10, w_m1, w_s10, w_s1;
  logic       w_min_max;

  assign o_time      = {r_m10, r_m1, r_s10, r_s1};
  assign w_min_max   = (r_m10 == MAX_M10) && (r_m1 == MAX_M1);
  assign o_is_max    = w_min_max && (r_s10 == 4'd5) && (r_s1 == 4'd9);
  assign o_next_max  = w_min_max && (r_s10 == 4'd5) && (r_s1 == 4'd8);
  assign o_is_zero   = (o_time == 16'h0000);
  assign o_next_zero = (o_time == 16'h0001);

  // Terminal values are hard stops: inc at max and dec at zero are ignored.
  always_comb begin
    w_m10 = r_m10;
    w_m1  = r_m1;
    w_s10 = r_s10;
    w_s1  = r_s1;
    if (i_clr) begin
      w_m10 = '0; w_m1 = '0; w_s10 = '0; w_s1 = '0;
    end else if (i_ld) begin
      {w_m10, w_m1, w_s10, w_s1} = i_ld_val;
    end else if (i_inc && !o_is_max) begin
      if (r_s1 != 4'd9) w_s1 = r_s1 + 4'd1;
      else begin
        w_s1 = 4'd0;
        if (r_s10 != 4'd5) w_s10 = r_s10 + 4'd1;
        else begin
          w_s10 = 4'd0;
          if (r_m1 != 4'd9) w_m1 = r_m1 + 4'd1;
          else begin
            w_m1  = 4'd0;
            w_m10 = r_m10 + 4'd1;
          end
        end
      end
    end else if (i_dec && !o_is_zero) begin
      if (r_s1 != 4'd0) w_s1 = r_s1 - 4'd1;
      else begin
        w_s1 = 4'd9;
        if (r_s10 != 4'd0) w_s10 = r_s10 - 4'd1;
        else begin
          w_s10 = 4'd5;
          if (r_m1 != 4'd0) w_m1 = r_m1 - 4'd1;
          else begin
            w_m1  = 4'd9;
            w_m10 = r_m10 - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m10 <= '0; r_m1 <= '0; r_s10 <= '0; r_s1 <= '0;
    end else begin
      r_m10 <= w_m10; r_m1 <= w_m1; r_s10 <= w_s10; r_s1 <= w_s1;
    end
  end
endmodule

// File: rtl/stage_timer.sv
// stage_timer: BCD mm:ss stopwatch / countdown for the stage FSM.
//   clk   system clock
//   rst   asynchronous active-high reset (clears the best-time record too)
//   tmr   stage_timer_if.slave: control pulses in, time displays and status out
// Parameters: TICK_DIV clk cycles per second (>=2), MAX_MIN count-up limit in
// minutes (1..99), BLANK_CODE shown on nums while blank is high.
module stage_timer
  import game_pkg::*;
#(
  parameter int          TICK_DIV   = 100000000,
  parameter int          MAX_MIN    = 99,
  parameter logic [15:0] BLANK_CODE = BLANK_CODE_DEFAULT
) (
  input logic         clk,
  input logic         rst,
  stage_timer_if.slave tmr
);
  localparam int               DIV_W    = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  timer_state_t     r_state;
  logic [DIV_W-1:0] r_div;
  logic             r_dir;       // 1 = counting down
  logic [15:0]      r_nums;
  logic [15:0]      r_best;
  logic             r_best_valid;
  logic             r_running;
  logic             r_expired;
  logic             r_saturated;
  logic             r_load_err;

  logic [15:0] w_time;
  logic        w_is_zero, w_is_max, w_next_zero, w_next_max;
  logic        w_tick, w_load_ok, w_run_act, w_inc, w_dec, w_cnt_ld;

  assign w_tick    = (r_state == ST_RUN) && (r_div == DIV_LAST);
  assign w_load_ok = preset_ok(tmr.preset_bcd, 7'(MAX_MIN));
  assign w_cnt_ld  = !tmr.clear && tmr.load && w_load_ok;
  // Any load (even a rejected one) and any pause make the cycle a hold cycle,
  // so a coincident tick is dropped rather than half-applied.
  assign w_run_act = !tmr.clear && !tmr.load && !tmr.pause && (r_state == ST_RUN);
  assign w_inc     = w_run_act && w_tick && !r_dir;
  assign w_dec     = w_run_act && w_tick && r_dir;

  bcd_mmss_counter #(.MAX_MIN(MAX_MIN)) u_counter (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (tmr.clear),
    .i_ld       (w_cnt_ld),
    .i_ld_val   (tmr.preset_bcd),
    .i_inc      (w_inc),
    .i_dec      (w_dec),
    .o_time     (w_time),
    .o_is_zero  (w_is_zero),
    .o_is_max   (w_is_max),
    .o_next_zero(w_next_zero),
    .o_next_max (w_next_max)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_div        <= '0;
      r_dir        <= 1'b0;
      r_nums       <= '0;
      r_best       <= '0;
      r_best_valid <= 1'b0;
      r_running    <= 1'b0;
      r_expired    <= 1'b0;
      r_saturated  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_nums     <= w_time;
      r_expired  <= 1'b0;
      r_load_err <= 1'b0;

      // BCD digit order makes the plain vector compare a numeric compare.
      if (tmr.capture && ((r_state == ST_PAUSE) || (r_state == ST_DONE)) && !r_dir &&
          (!r_best_valid || (w_time < r_best))) begin
        r_best       <= w_time;
        r_best_valid <= 1'b1;
      end

      if (tmr.clear) begin
        r_state     <= ST_IDLE;
        r_running   <= 1'b0;
        r_saturated <= 1'b0;
        r_div       <= '0;
      end else if (tmr.load) begin
        if (w_load_ok) begin
          r_state     <= ST_IDLE;
          r_running   <= 1'b0;
          r_saturated <= 1'b0;
          r_div       <= '0;
        end else begin
          r_load_err  <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (tmr.start) begin
              r_dir <= tmr.mode_down;
              r_div <= '0;
              if (tmr.mode_down && w_is_zero) begin
                r_state   <= ST_DONE;
                r_expired <= 1'b1;
              end else if (!tmr.mode_down && w_is_max) begin
                r_state     <= ST_DONE;
                r_saturated <= 1'b1;
              end else begin
                r_state   <= ST_RUN;
                r_running <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (tmr.pause) begin
              r_state   <= ST_PAUSE;
              r_running <= 1'b0;
            end else if (w_tick) begin
              r_div <= '0;
              if (!r_dir && w_next_max) begin
                r_state     <= ST_DONE;
                r_running   <= 1'b0;
                r_saturated <= 1'b1;
              end else if (r_dir && w_next_zero) begin
                r_state   <= ST_DONE;
                r_running <= 1'b0;
                r_expired <= 1'b1;
              end
            end else begin
              r_div <= r_div + DIV_W'(1);
            end
          end
          ST_PAUSE: begin
            if (tmr.start) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
          default: ;  // ST_DONE: frozen until clear/load/rst
        endcase
      end
    end
  end

  assign tmr.nums       = tmr.blank ? BLANK_CODE : r_nums;
  assign tmr.best_nums  = r_best;
  assign tmr.best_valid = r_best_valid;
  assign tmr.running    = r_running;
  assign tmr.expired    = r_expired;
  assign tmr.saturated  = r_saturated;
  assign tmr.load_err   = r_load_err;
  assign tmr.dbg_state  = r_state;
endmodule

// File: tb/tb_stage_timer.sv
module tb_stage_timer;
  localparam int          TICK_DIV = 4;
  localparam int          MAX_MIN  = 2;
  localparam logic [15:0] BLANK    = 16'hAAAA;
  localparam int          MAX_SECS = MAX_MIN * 60 + 59;

  typedef struct packed {
    logic [15:0] nums;
    logic [15:0] best;
    logic        bv;
    logic        run;
    logic        exp;
    logic        sat;
    logic        lerr;
  } snap_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stage_timer_if tif ();

  stage_timer #(.TICK_DIV(TICK_DIV), .MAX_MIN(MAX_MIN), .BLANK_CODE(BLANK)) dut (
    .clk(clk),
    .rst(rst),
    .tmr(tif)
  );

  // ---------------- reference model (seconds as a plain integer) ----------------
  // states: 0 idle, 1 running, 2 paused, 3 finished
  int          m_state, m_secs, m_div, m_best;
  bit          m_down, m_best_valid, m_sat, m_exp, m_lerr;
  logic [15:0] m_nums_reg;

  logic [$bits(snap_t)-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // returns -1 for an unacceptable preset, else the preset in seconds
  function automatic int preset_secs(input logic [15:0] p);
    int d3, d2, d1, d0;
    d3 = int'(p[15:12]); d2 = int'(p[11:8]); d1 = int'(p[7:4]); d0 = int'(p[3:0]);
    if (d3 > 9 || d2 > 9 || d1 > 5 || d0 > 9) return -1;
    if (d3 * 10 + d2 > MAX_MIN) return -1;
    return (d3 * 10 + d2) * 60 + d1 * 10 + d0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_secs = 0; m_div = 0; m_best = 0; m_down = 0;
    m_best_valid = 0; m_sat = 0; m_exp = 0; m_lerr = 0; m_nums_reg = '0;
  endtask

  task automatic model_step(input bit st, pa, cl, ld, input logic [15:0] pre,
                            input bit md, cap);
    int pre_secs, ps;
    pre_secs   = m_secs;
    m_nums_reg = to_bcd(pre_secs);
    m_exp  = 0;
    m_lerr = 0;
    if (cap && (m_state == 2 || m_state == 3) && !m_down &&
        (!m_best_valid || pre_secs < m_best)) begin
      m_best = pre_secs;
      m_best_valid = 1;
    end
    ps = preset_secs(pre);
    if (cl) begin
      m_secs = 0; m_state = 0; m_sat = 0; m_div = 0;
    end else if (ld) begin
      if (ps >= 0) begin
        m_secs = ps; m_state = 0; m_sat = 0; m_div = 0;
      end else m_lerr = 1;
    end else if (m_state == 0) begin
      if (st) begin
        m_down = md;
        m_div  = 0;
        if (md && m_secs == 0) begin m_state = 3; m_exp = 1; end
        else if (!md && m_secs == MAX_SECS) begin m_state = 3; m_sat = 1; end
        else m_state = 1;
      end
    end else if (m_state == 1) begin
      if (pa) m_state = 2;
      else if (m_div == TICK_DIV - 1) begin
        m_div = 0;
        if (!m_down) begin
          m_secs = m_secs + 1;
          if (m_secs == MAX_SECS) begin m_state = 3; m_sat = 1; end
        end else begin
          m_secs = m_secs - 1;
          if (m_secs == 0) begin m_state = 3; m_exp = 1; end
        end
      end else m_div = m_div + 1;
    end else if (m_state == 2) begin
      if (st) m_state = 1;
    end
  endtask

  task automatic push_exp(input bit bl);
    snap_t e;
    e.nums = bl ? BLANK : m_nums_reg;
    e.best = to_bcd(m_best);
    e.bv   = m_best_valid;
    e.run  = (m_state == 1);
    e.exp  = m_exp;
    e.sat  = m_sat;
    e.lerr = m_lerr;
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit st, pa, cl, ld, input logic [15:0] pre,
                       input bit md, cap, bl, rs);
    @(posedge clk);
    #1;
    rst            = rs;
    tif.start      = st;
    tif.pause      = pa;
    tif.clear      = cl;
    tif.load       = ld;
    tif.preset_bcd = pre;
    tif.mode_down  = md;
    tif.capture    = cap;
    tif.blank      = bl;
    if (rs) begin
      model_reset();
      push_exp(bl);
    end else begin
      push_exp(bl);
      model_step(st, pa, cl, ld, pre, md, cap);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 16'h0, 0, 0, 0, 0);
  endtask
  task automatic do_load(input logic [15:0] v); cycle(0, 0, 0, 1, v, 0, 0, 0, 0); endtask
  task automatic do_start(input bit md);        cycle(1, 0, 0, 0, 16'h0, md, 0, 0, 0); endtask
  task automatic do_pause();                    cycle(0, 1, 0, 0, 16'h0, 0, 0, 0, 0); endtask
  task automatic do_clear();                    cycle(0, 0, 1, 0, 16'h0, 0, 0, 0, 0); endtask
  task automatic do_capture();                  cycle(0, 0, 0, 0, 16'h0, 0, 1, 0, 0); endtask

  task automatic run_to(input int secs);
    for (int i = 0; i < 2000 && m_secs < secs; i++) idle(1);
  endtask

  // ---------------- scoreboard monitor ----------------
  function automatic bit fld(input string nm, input logic [15:0] got, input logic [15:0] want);
    if (got !== want) begin
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, got, want, $time);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  snap_t mon_e;
  bit    mon_b;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_b = 0;
      mon_b |= fld("nums",       tif.nums,                mon_e.nums);
      mon_b |= fld("best_nums",  tif.best_nums,           mon_e.best);
      mon_b |= fld("best_valid", {15'b0, tif.best_valid}, {15'b0, mon_e.bv});
      mon_b |= fld("running",    {15'b0, tif.running},    {15'b0, mon_e.run});
      mon_b |= fld("expired",    {15'b0, tif.expired},    {15'b0, mon_e.exp});
      mon_b |= fld("saturated",  {15'b0, tif.saturated},  {15'b0, mon_e.sat});
      mon_b |= fld("load_err",   {15'b0, tif.load_err},   {15'b0, mon_e.lerr});
      total++;
      if (mon_b) bad++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    tif.start = 0; tif.pause = 0; tif.clear = 0; tif.load = 0;
    tif.preset_bcd = '0; tif.mode_down = 0; tif.capture = 0; tif.blank = 0;
    model_reset();

    // reset, including blank during reset
    cycle(0, 0, 0, 0, 16'h0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 16'h0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 16'h0, 0, 0, 0, 1);
    idle(2);

    // count up across the minute boundary, with blank mid-run
    do_load(16'h0058); do_start(0); idle(6);
    cycle(0, 0, 0, 0, 16'h0, 0, 0, 1, 0);
    idle(8);

    // countdown to expiry, then a start that must be ignored
    do_load(16'h0003); do_start(1); idle(14);
    do_start(1); idle(3);

    // pause keeps the fraction of a second
    do_clear(); do_start(0); idle(5); do_pause(); idle(50);
    do_start(0); idle(6);

    // saturation at MAX_MIN:59 and its release by clear
    do_load(16'h0257); do_start(0); idle(8); idle(40);
    do_clear(); idle(2);

    // preset validation
    do_load(16'h0360); idle(1); do_load(16'h0160); do_load(16'h0259); idle(2);
    do_load(16'h0A00); idle(1); do_load(16'h0259); do_start(0); idle(2);

    // best-time record
    do_clear(); do_start(0); run_to(5); do_pause(); do_capture(); idle(1);
    do_start(0); run_to(9); do_pause(); do_capture(); idle(1);
    do_clear(); do_start(0); run_to(3); do_pause(); do_capture(); idle(1);
    // countdown paused: capture must be ignored
    do_clear(); do_load(16'h0002); do_start(1); idle(2); do_pause(); do_capture(); idle(1);

    // asynchronous reset mid-run
    do_clear(); do_start(0); idle(6);
    cycle(0, 0, 0, 0, 16'h0, 0, 0, 0, 1);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit st, pa, cl, ld, md, cap, bl, rs;
      logic [15:0] pre;
      st  = ($urandom_range(0, 7) == 0);
      pa  = ($urandom_range(0, 15) == 0);
      cl  = ($urandom_range(0, 59) == 0);
      ld  = ($urandom_range(0, 24) == 0);
      md  = 1'($urandom_range(0, 1));
      cap = ($urandom_range(0, 5) == 0);
      bl  = ($urandom_range(0, 9) == 0);
      rs  = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 1) == 0) pre = to_bcd($urandom_range(0, MAX_SECS));
      else if ($urandom_range(0, 1) == 0) pre = to_bcd($urandom_range(0, 10));
      else pre = 16'($urandom);
      cycle(st, pa, cl, ld, pre, md, cap, bl, rs);
    end
    idle(2);

    // let the monitor drain the queue
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      total++;
      bad++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stage_timer.md
Name: stage_timer

Overview:
- Parametrised successor to the per-stage game timer: BCD mm:ss stopwatch/countdown for the stage FSM.
- Adds explicit run/pause/clear control, preset load, count-down mode with expiry flag, saturation at a configurable maximum, and a best-time record.
- Sits between the top-level game FSM, which drives control pulses, and the 7-segment driver, which consumes `nums`/`best_nums`.

Parameters:
- TICK_DIV, 100000000: clk cycles per one-second tick; must be ≥2.
- MAX_MIN, 99: maximum minute value, 1..99; count-up saturates at MAX_MIN:59.
- BLANK_CODE, 16'hAAAA: value driven on `nums` while `blank`=1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  pulse: IDLE/PAUSE → RUN
- pause  in  1  pulse: RUN → PAUSE
- clear  in  1  pulse: time := 00:00, → IDLE (best kept)
- load  in  1  pulse: time := preset_bcd, → IDLE
- preset_bcd  in  16  {m10,m1,s10,s1} BCD preset
- mode_down  in  1  1 = count down, 0 = count up; sampled only on start from IDLE
- capture  in  1  pulse: offer current time to best-time record
- blank  in  1  force `nums` = BLANK_CODE
- nums  out  16  {m10,m1,s10,s1} current time BCD
- best_nums  out  16  best (lowest) captured time BCD
- best_valid  out  1  best_nums holds a captured value
- running  out  1  state==RUN
- expired  out  1  one-cycle pulse when countdown reaches 00:00
- saturated  out  1  level: count-up hit MAX_MIN:59
- load_err  out  1  one-cycle pulse: load rejected

Behaviour:
- Reset values: time=00:00, nums=0000 (or BLANK_CODE if blank=1), best_nums=0, best_valid=0, running=0, expired=0, saturated=0, load_err=0, divider=0, state=IDLE, dir=up.
- States IDLE, RUN, PAUSE, DONE. Input priority: rst > clear > load > start > pause; capture is independent.
- Time register holds four BCD digits, each 0..9, s10 ≤5; no binary→BCD division.
- Divider: 0..TICK_DIV-1, advances only in RUN. tick = RUN && div==TICK_DIV-1. Zeroed on start from IDLE, clear, load. Held in PAUSE, so resume keeps the fraction.
- IDLE: start → RUN, latch dir=mode_down, div=0. In down mode with time==00:00, start → DONE with expired pulse next cycle.
- RUN: pause → PAUSE. On tick:
  - up: s1 → s10 → m1 → m10 BCD carry chain, sec wraps 59→00 with min+1. The tick that produces MAX_MIN:59 → DONE, saturated=1; never exceeds it.
  - down: borrow chain, 00 sec → 59 with min-1. The tick producing 00:00 → DONE, expired=1 for exactly one cycle.
- PAUSE: start → RUN (dir unchanged); time frozen.
- DONE: time frozen; start ignored; only clear/load/rst leave. saturated clears on leaving DONE.
- clear: any state → IDLE, time=00:00, saturated=0. Same-cycle tick is discarded.
- load: valid if every digit ≤9, s10 ≤5, and 10*m10+m1 ≤ MAX_MIN. Valid → time=preset, IDLE. Invalid → state/time unchanged, load_err pulses one cycle.
- capture: accepted in PAUSE or DONE with dir=up only.
  - If !best_valid or time < best_nums (lexicographic compare of BCD digits == numeric compare), best_nums := time and best_valid := 1 next cycle.
  - Ignored otherwise.
  - Capture simultaneous with clear/load uses the pre-clear time.
- Outputs nums/best_nums are registered: one-cycle latency from the time register.
- Async reset mid-RUN returns everything to reset values immediately; best record is lost.

Decomposition:
- Shared package `game_pkg`: stage timer state enum, BCD digit typedef (4-bit), BLANK_CODE default, and the game stage codes (TITLE=0 … FAIL=8) used by the top FSM to generate start/clear.
- One natural sub-module: `bcd_mmss_counter` (4-digit BCD up/down counter with inc/dec enable, load, wrap/borrow, and terminal flags is_zero, is_max).
- The stage_timer wraps it with the FSM, divider, validation and best-time logic.

Test Plan:
- All tests use TICK_DIV=4, MAX_MIN=2.
- Reset, load 16'h0058, start up, 12 clk → nums=16'h0101 (58→59→100→101), running=1.
- Load 16'h0003, mode_down=1, start; after 12 clk → nums=0000, expired high exactly 1 cycle, state DONE. A further start produces no change.
- Up from 00:00, pause after 6 clk (time 00:01, div=2), wait 50 clk → unchanged. Start → next tick after 2 clk → 00:02.
- Load 16'h0257, up; 8 clk → 02:59, saturated=1, then frozen for 40 clk. Clear → 0000, saturated=0.
- Load 16'h0360 → load_err pulse, time unchanged. Load 16'h0160 → load_err. Load 16'h0259 → accepted.
- Capture at PAUSE 00:05 → best=0005, valid=1. Capture at 00:09 → best stays 0005. Capture at 00:03 → best=0003. Assert rst mid-RUN → all outputs at reset values same cycle.
